// File: rtl/usart_pkg.sv
// Shared USART definitions: widths, FSM encoding, frame geometry and line levels.
package usart_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned REQ_N  = 2;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CNT_W  = 16;

  // Line levels driven by the serializer for the framing bits
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FRAME = 2'd2
  } state_e;

  // Start bit + 8 data bits + stop bits
  function automatic int unsigned frame_bits(input int unsigned stop_bits);
    return 32'd9 + stop_bits;
  endfunction

  // Winner index: a lone requester wins; on contention the one not granted last wins
  function automatic logic rr_pick(input logic [REQ_N-1:0] req, input logic last);
    if (req == 2'b11) begin
      return ~last;
    end
    return req[1];
  endfunction

endpackage

// File: rtl/usart_baud_gen.sv
// Bit-time counter; TICK is a registered pulse during the last cycle of each bit slot.
module usart_baud_gen
  import usart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 14
) (
  input  logic CLK,
  input  logic CLR_N,
  input  logic RUN,
  output logic TICK
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Counter parks at zero while idle so the first running cycle is slot cycle 0
  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (RUN) begin
      cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
    end
    tick_d = (cnt_d == LAST_CNT);
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign TICK = tick_q;

endmodule

// File: rtl/usart_tx_ctrl.sv
// USART transmit control: round-robin grant of two byte requesters and frame sequencing.
module usart_tx_ctrl
  import usart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 14,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic              EN,
  input  logic [REQ_N-1:0]  REQ,
  input  logic [DATA_W-1:0] DATA0,
  input  logic [DATA_W-1:0] DATA1,
  output logic [REQ_N-1:0]  GNT,
  output logic              TX_LOAD,
  output logic [DATA_W-1:0] TX_DATA,
  output logic [IDX_W-1:0]  BIT_IDX,
  output logic              BIT_TICK,
  output logic              BUSY,
  output logic              DONE
);

  localparam int unsigned      NBITS    = frame_bits(STOP_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBITS - 1);

  state_e             state_q, state_d;
  logic [REQ_N-1:0]   gnt_q, gnt_d;
  logic               load_q, load_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               last_q, last_d;
  logic               win;
  logic               baud_run;
  logic               tick;

  assign baud_run = (state_q == ST_FRAME);

  usart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .CLK  (CLK),
    .CLR_N(CLR_N),
    .RUN  (baud_run),
    .TICK (tick)
  );

  assign win = rr_pick(REQ, last_q);

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    load_d  = 1'b0;
    data_d  = data_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (EN && (REQ != '0)) begin
          state_d = ST_LOAD;
          gnt_d   = win ? 2'b10 : 2'b01;
          load_d  = 1'b1;
          data_d  = win ? DATA1 : DATA0;
          last_d  = win;
          idx_d   = '0;
        end
      end
      ST_LOAD: begin
        state_d = ST_FRAME;
        idx_d   = '0;
      end
      ST_FRAME: begin
        // tick is high in the slot's last cycle, so this edge closes the slot
        if (tick) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      load_q  <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      load_q  <= load_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      last_q  <= last_d;
    end
  end

  assign GNT      = gnt_q;
  assign TX_LOAD  = load_q;
  assign TX_DATA  = data_q;
  assign BIT_IDX  = idx_q;
  assign BIT_TICK = tick;
  assign BUSY     = busy_q;
  assign DONE     = done_q;

endmodule
